// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the I/D memory request sequencer.
// Holds the FSM state and read-owner encodings plus the byte-lane merge used for partial stores.
package mem_seq_pkg;

    localparam int SEQ_ADDR_W = 30;
    localparam int SEQ_DATA_W = 32;
    localparam int BE_W       = SEQ_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW_WR  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Lanes with be[k] set take new_word, all others keep old_word.
    function automatic logic [SEQ_DATA_W-1:0] merge_bytes(
        input logic [SEQ_DATA_W-1:0] old_word,
        input logic [SEQ_DATA_W-1:0] new_word,
        input logic [BE_W-1:0]       be
    );
        logic [SEQ_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational per-byte mux: builds the read-modify-write word from the old memory word
// and the lane-aligned store data.
module byte_lane_merge
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W
) (
    input  logic [DATA_W-1:0]   old_word_i,
    input  logic [DATA_W-1:0]   new_word_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);

    for (genvar k = 0; k < DATA_W / 8; k++) begin : g_lane
        assign merged_o[8*k +: 8] = be_i[k] ? new_word_i[8*k +: 8] : old_word_i[8*k +: 8];
    end

endmodule

// File: rtl/mem_request_sequencer.sv
// Arbitrates the CPU fetch (I) and load/store (D) ports onto one single-port word memory.
// Partial stores become a read followed by a merged full-word write.
//
// state   | meaning
// IDLE    | accepting requests; full stores and empty-mask stores complete here
// RD_WAIT | one read outstanding; owner_q says whether it belongs to I or D
// RMW_WR  | old word has arrived; write back the byte-merged word
module mem_request_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DATA_W = SEQ_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,

    input  logic                i_valid,
    output logic                i_ready,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_valid,
    output logic                d_ready,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,

    output logic                mem_en,
    output logic                mem_rren,
    output logic                mem_wren,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_N = DATA_W / 8;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_N-1:0]     be_q, be_d;

    logic                i_rvalid_q, i_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic                d_done_q, d_done_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic [DATA_W-1:0]   rmw_word;

    byte_lane_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_word_i (mem_rdata),
        .new_word_i (wdata_q),
        .be_i       (be_q),
        .merged_o   (rmw_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_done_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            d_done_q   <= d_done_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Everything combinational is forced low while rst is high so an abandoned
    // RMW never reaches the memory in the reset cycle.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        d_done_d   = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        mem_en     = 1'b0;
        mem_rren   = 1'b0;
        mem_wren   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (d_valid) begin
                        d_ready = 1'b1;
                        owner_d = OWN_D;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                        if (!d_we) begin
                            mem_en   = 1'b1;
                            mem_rren = 1'b1;
                            mem_addr = d_addr;
                            state_d  = RD_WAIT;
                        end else if (&d_be) begin
                            mem_en    = 1'b1;
                            mem_wren  = 1'b1;
                            mem_addr  = d_addr;
                            mem_wdata = d_wdata;
                            d_done_d  = 1'b1;
                        end else if (|d_be) begin
                            mem_en   = 1'b1;
                            mem_rren = 1'b1;
                            mem_addr = d_addr;
                            state_d  = RMW_WR;
                        end else begin
                            d_done_d = 1'b1;
                        end
                    end else if (i_valid && !flush) begin
                        i_ready  = 1'b1;
                        owner_d  = OWN_I;
                        addr_d   = i_addr;
                        mem_en   = 1'b1;
                        mem_rren = 1'b1;
                        mem_addr = i_addr;
                        state_d  = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state_d = IDLE;
                    if (owner_q == OWN_D) begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        i_rdata_d  = mem_rdata;
                        i_rvalid_d = !flush;
                    end
                end
                RMW_WR: begin
                    mem_en    = 1'b1;
                    mem_wren  = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = rmw_word;
                    d_done_d  = 1'b1;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_done   = d_done_q;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Bench for mem_request_sequencer: one-cycle memory model, reference memory and
// scoreboard queues for fetch/load data and store completions.
module tb_mem_request_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        i_valid, i_ready, i_rvalid;
    logic [29:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_valid, d_ready, d_we, d_rvalid, d_done;
    logic [29:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_en, mem_rren, mem_wren;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'h0;
    logic [31:0] bd_data = 32'h0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    int          done_exp  = 0;
    int          done_seen = 0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_request_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_addr    (i_addr),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_en    (mem_en),
        .mem_rren  (mem_rren),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_rren) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) chk("rren_wren_exclusive", {63'd0, mem_rren & mem_wren}, 64'd0);
            if (i_rvalid) begin
                chk("i_rvalid_expected", {63'd0, exp_i.size() > 0}, 64'd1);
                if (exp_i.size() > 0) chk("i_rdata", {32'd0, i_rdata}, {32'd0, exp_i.pop_front()});
            end
            if (d_rvalid) begin
                chk("d_rvalid_expected", {63'd0, exp_d.size() > 0}, 64'd1);
                if (exp_d.size() > 0) chk("d_rdata", {32'd0, d_rdata}, {32'd0, exp_d.pop_front()});
            end
            if (d_done) begin
                chk("d_done_expected", {63'd0, done_exp > done_seen}, 64'd1);
                done_seen++;
            end
        end
    end

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        ref_mem[a] = v;
        step();
        bd_we = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int c = 0; c < 20; c++) begin
            if (exp_i.size() == 0 && exp_d.size() == 0 && done_seen == done_exp) break;
            step();
        end
        left = exp_i.size() + exp_d.size() + (done_exp - done_seen);
        chk("drain_outstanding", 64'(left), 64'd0);
    endtask

    task automatic d_op(input logic we, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be);
        int tries;
        tries = 0;
        d_valid = 1'b1; d_we = we; d_addr = {22'd0, a}; d_wdata = wd; d_be = be;
        #1;
        while (!d_ready && tries < 10) begin
            step();
            tries++;
        end
        chk("d_accept", {63'd0, d_ready}, 64'd1);
        if (!we) begin
            exp_d.push_back(ref_mem[a]);
        end else begin
            ref_mem[a] = ref_merge(ref_mem[a], wd, be);
            done_exp++;
        end
        step();
        d_valid = 1'b0;
    endtask

    task automatic i_op(input logic [7:0] a);
        int tries;
        tries = 0;
        i_valid = 1'b1; i_addr = {22'd0, a};
        #1;
        while (!i_ready && tries < 10) begin
            step();
            tries++;
        end
        chk("i_accept", {63'd0, i_ready}, 64'd1);
        exp_i.push_back(ref_mem[a]);
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (3) step();
        d_valid = 1'b1; d_we = 1'b0; d_addr = 30'd1;
        #1;
        chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_addr", {34'd0, mem_addr}, 64'd0);
        d_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("rst_i_rvalid", {63'd0, i_rvalid}, 64'd0);
        chk("rst_d_done", {63'd0, d_done}, 64'd0);
        chk("rst_i_rdata", {32'd0, i_rdata}, 64'd0);
        chk("rst_d_rdata", {32'd0, d_rdata}, 64'd0);

        // 1: simple fetch latency
        preload(8'd0, 32'h24080001);
        i_valid = 1'b1; i_addr = 30'd0;
        #1;
        chk("t1_i_ready", {63'd0, i_ready}, 64'd1);
        chk("t1_mem_rren", {63'd0, mem_rren}, 64'd1);
        chk("t1_mem_wren", {63'd0, mem_wren}, 64'd0);
        exp_i.push_back(ref_mem[0]);
        step();
        i_valid = 1'b0;
        #1;
        chk("t1_n1_rvalid", {63'd0, i_rvalid}, 64'd0);
        chk("t1_n1_mem_en", {63'd0, mem_en}, 64'd0);
        step();
        chk("t1_n2_rvalid", {63'd0, i_rvalid}, 64'd1);
        chk("t1_n2_rdata", {32'd0, i_rdata}, 64'h24080001);
        drain();

        // 2: same-cycle conflict, D wins, I waits then goes in N+2
        preload(8'd5, 32'hA5A50005);
        preload(8'd7, 32'h0BADF00D);
        i_valid = 1'b1; i_addr = 30'd7;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 30'd5; d_be = 4'hF;
        #1;
        chk("t2_d_ready", {63'd0, d_ready}, 64'd1);
        chk("t2_i_ready", {63'd0, i_ready}, 64'd0);
        chk("t2_mem_addr", {34'd0, mem_addr}, 64'd5);
        exp_d.push_back(ref_mem[5]);
        step();
        d_valid = 1'b0;
        #1;
        chk("t2_n1_i_ready", {63'd0, i_ready}, 64'd0);
        step();
        chk("t2_n2_d_rvalid", {63'd0, d_rvalid}, 64'd1);
        chk("t2_n2_i_ready", {63'd0, i_ready}, 64'd1);
        chk("t2_n2_mem_addr", {34'd0, mem_addr}, 64'd7);
        exp_i.push_back(ref_mem[7]);
        step();
        i_valid = 1'b0;
        drain();

        // 3: full store then load; back-to-back full stores
        d_valid = 1'b1; d_we = 1'b1; d_addr = 30'd10; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        #1;
        chk("t3_d_ready", {63'd0, d_ready}, 64'd1);
        chk("t3_mem_wren", {63'd0, mem_wren}, 64'd1);
        chk("t3_mem_rren", {63'd0, mem_rren}, 64'd0);
        chk("t3_mem_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
        ref_mem[10] = 32'hDEADBEEF;
        done_exp++;
        step();
        d_valid = 1'b0;
        #1;
        chk("t3_n1_done", {63'd0, d_done}, 64'd1);
        d_op(1'b0, 8'd10, 32'h0, 4'hF);
        drain();
        d_valid = 1'b1; d_we = 1'b1; d_addr = 30'd11; d_wdata = 32'h11111111; d_be = 4'hF;
        #1;
        ref_mem[11] = 32'h11111111; done_exp++;
        step();
        d_addr = 30'd12; d_wdata = 32'h22222222;
        #1;
        chk("t3_b2b_ready", {63'd0, d_ready}, 64'd1);
        chk("t3_b2b_done", {63'd0, d_done}, 64'd1);
        ref_mem[12] = 32'h22222222; done_exp++;
        step();
        d_valid = 1'b0;
        d_op(1'b0, 8'd11, 32'h0, 4'hF);
        d_op(1'b0, 8'd12, 32'h0, 4'hF);
        drain();

        // 4: partial store via read-modify-write, then empty-mask store
        preload(8'd10, 32'h11223344);
        d_valid = 1'b1; d_we = 1'b1; d_addr = 30'd10; d_wdata = 32'h0000AA00; d_be = 4'b0010;
        #1;
        chk("t4_d_ready", {63'd0, d_ready}, 64'd1);
        chk("t4_n0_rren", {63'd0, mem_rren}, 64'd1);
        chk("t4_n0_wren", {63'd0, mem_wren}, 64'd0);
        ref_mem[10] = ref_merge(ref_mem[10], 32'h0000AA00, 4'b0010);
        done_exp++;
        step();
        d_valid = 1'b0;
        #1;
        chk("t4_n1_wren", {63'd0, mem_wren}, 64'd1);
        chk("t4_n1_rren", {63'd0, mem_rren}, 64'd0);
        chk("t4_n1_addr", {34'd0, mem_addr}, 64'd10);
        chk("t4_n1_wdata", {32'd0, mem_wdata}, 64'h1122AA44);
        chk("t4_n1_d_done", {63'd0, d_done}, 64'd0);
        step();
        chk("t4_n2_done", {63'd0, d_done}, 64'd1);
        d_op(1'b0, 8'd10, 32'h0, 4'hF);
        drain();
        d_valid = 1'b1; d_we = 1'b1; d_addr = 30'd10; d_wdata = 32'hFFFFFFFF; d_be = 4'b0000;
        #1;
        chk("t4_be0_ready", {63'd0, d_ready}, 64'd1);
        chk("t4_be0_mem_en", {63'd0, mem_en}, 64'd0);
        done_exp++;
        step();
        d_valid = 1'b0;
        #1;
        chk("t4_be0_done", {63'd0, d_done}, 64'd1);
        d_op(1'b0, 8'd10, 32'h0, 4'hF);
        drain();

        // 5: flush during fetch RD_WAIT squashes the fetch; D still served under flush
        preload(8'd3, 32'hC0FFEE03);
        i_valid = 1'b1; i_addr = 30'd3;
        #1;
        chk("t5_i_ready", {63'd0, i_ready}, 64'd1);
        step();
        flush = 1'b1;
        #1;
        chk("t5_n1_i_ready", {63'd0, i_ready}, 64'd0);
        step();
        chk("t5_n2_i_rvalid", {63'd0, i_rvalid}, 64'd0);
        chk("t5_n2_i_ready", {63'd0, i_ready}, 64'd0);
        i_valid = 1'b0;
        d_op(1'b0, 8'd3, 32'h0, 4'hF);
        flush = 1'b0;
        drain();

        // 6: reset during RMW_WR abandons the write and the completion pulse
        preload(8'd15, 32'h55667788);
        d_valid = 1'b1; d_we = 1'b1; d_addr = 30'd15; d_wdata = 32'h000000FF; d_be = 4'b0001;
        #1;
        chk("t6_d_ready", {63'd0, d_ready}, 64'd1);
        step();
        d_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_wren", {63'd0, mem_wren}, 64'd0);
        chk("t6_rst_mem_en", {63'd0, mem_en}, 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_after_done", {63'd0, d_done}, 64'd0);
        chk("t6_after_mem_en", {63'd0, mem_en}, 64'd0);
        chk("t6_after_i_rdata", {32'd0, i_rdata}, 64'd0);
        d_op(1'b0, 8'd15, 32'h0, 4'hF);
        drain();

        // random mix of fetches, loads and stores with arbitrary byte masks
        for (int a = 32; a < 48; a++) preload(8'(a), $urandom);
        for (int n = 0; n < 60; n++) begin
            logic [7:0] ra;
            ra = 8'(32 + $urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       i_op(ra);
                1:       d_op(1'b0, ra, 32'h0, 4'hF);
                default: d_op(1'b1, ra, $urandom, 4'($urandom_range(0, 15)));
            endcase
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
